// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register-file constants and clear-engine state type
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// rtl/reg_file_clr_ctrl.sv - bulk-clear sequencer: walks every entry once, then pulses done
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              idle,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_done  = 1'b0;
    idle      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        idle    = 1'b1;
        cnt_nxt = '0;
        if (clr_req) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        // last entry is zeroed on the same edge that leaves CLEAR
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        clr_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with bulk clear; REG_FILE_BYPASS_EN adds write-to-read forwarding
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  reg_file_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .idle     (idle),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok = idle && we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // hardwired zero is applied last so it also overrides any forwarded value
  always_comb begin
    rdata_a = mem[raddr_a];
`ifdef REG_FILE_BYPASS_EN
    if (idle && we && (waddr == raddr_a)) rdata_a = wdata;
`endif
    if ((ZERO_REG != 0) && (raddr_a == '0)) rdata_a = '0;
  end

  always_comb begin
    rdata_b = mem[raddr_b];
`ifdef REG_FILE_BYPASS_EN
    if (idle && we && (waddr == raddr_b)) rdata_b = wdata;
`endif
    if ((ZERO_REG != 0) && (raddr_b == '0)) rdata_b = '0;
  end

endmodule
